// File: rtl/spec_dispatch_staller.sv
// Dispatch gate between the IFQ head and dispatch: tracks up to MAX_BRANCHES
// outstanding speculative branches as a circular tag queue, holds on JALR, flushes on mispredict.
module spec_dispatch_staller #(
  parameter int MAX_BRANCHES    = 2,
  parameter bit BLOCK_ON_BRANCH = 1'b0,
  parameter int TAG_W           = (MAX_BRANCHES > 1) ? $clog2(MAX_BRANCHES) : 1,
  parameter int CNT_W           = $clog2(MAX_BRANCHES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifq_empty,
  input  logic                    branch,
  input  logic                    jalr,
  input  logic                    branch_solved,
  input  logic                    branch_mispredict,
  input  logic                    jalr_solved,
  output logic                    nstall,
  output logic [TAG_W-1:0]        dispatch_tag,
  output logic [MAX_BRANCHES-1:0] branch_add_reg_en,
  output logic [TAG_W-1:0]        oldest_tag,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    flush,
  output logic [1:0]              state_dbg
);

  // Handshake: the IFQ head is consumed in any cycle where !ifq_empty && nstall;
  // the head is held (not consumed) in every other cycle, with no other qualifier.

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_JALR_WAIT = 2'd1,
    ST_FLUSH     = 2'd2
  } state_e;

  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(MAX_BRANCHES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_BRANCHES);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, busy, br_fire, jalr_fire, solve_ok, mispredict;

  always_comb begin
    full   = (count_q == FULL_CNT);
    busy   = (count_q != '0);
    nstall = !ifq_empty && (state_q == ST_NORMAL) && !(branch && full)
             && !(BLOCK_ON_BRANCH && busy);
    br_fire    = nstall && branch;
    // branch wins when both decode bits are set
    jalr_fire  = nstall && jalr && !branch;
    solve_ok   = branch_solved && busy && (state_q != ST_FLUSH);
    mispredict = solve_ok && branch_mispredict;

    branch_add_reg_en = '0;
    for (int i = 0; i < MAX_BRANCHES; i++) begin
      branch_add_reg_en[i] = br_fire && (tail_q == TAG_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (br_fire) begin
      tail_d = (tail_q == LAST_TAG) ? '0 : tail_q + 1'b1;
    end
    if (solve_ok) begin
      head_d = (head_q == LAST_TAG) ? '0 : head_q + 1'b1;
    end
    if (br_fire && !solve_ok) begin
      count_d = count_q + 1'b1;
    end else if (!br_fire && solve_ok) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      ST_NORMAL:    if (jalr_fire) state_d = ST_JALR_WAIT;
      ST_JALR_WAIT: if (jalr_solved) state_d = ST_NORMAL;
      ST_FLUSH:     state_d = ST_NORMAL;
      default:      state_d = ST_NORMAL;
    endcase

    // A mispredict squashes everything younger, including this cycle's allocation.
    if (mispredict) begin
      state_d = ST_FLUSH;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dispatch_tag = tail_q;
  assign oldest_tag   = head_q;
  assign outstanding  = count_q;
  assign flush        = (state_q == ST_FLUSH);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_spec_dispatch_staller.sv
// Directed bench for spec_dispatch_staller: three instances (MAX=2, MAX=3, MAX=2 blocking)
// share clock and reset, each driven through its own input bits.
module tb_spec_dispatch_staller;

  logic       clk;
  logic       rst;
  logic [2:0] ifq_empty, branch, jalr, bsolved, bmisp, jsolved;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  logic       a_nstall, a_flush;
  logic [0:0] a_tag, a_old;
  logic [1:0] a_en, a_out, a_state;

  logic       b_nstall, b_flush;
  logic [1:0] b_tag, b_old, b_out, b_state;
  logic [2:0] b_en;

  logic       c_nstall, c_flush;
  logic [0:0] c_tag, c_old;
  logic [1:0] c_en, c_out, c_state;

  spec_dispatch_staller #(.MAX_BRANCHES(2), .BLOCK_ON_BRANCH(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ifq_empty(ifq_empty[0]), .branch(branch[0]), .jalr(jalr[0]),
    .branch_solved(bsolved[0]), .branch_mispredict(bmisp[0]), .jalr_solved(jsolved[0]),
    .nstall(a_nstall), .dispatch_tag(a_tag), .branch_add_reg_en(a_en), .oldest_tag(a_old),
    .outstanding(a_out), .flush(a_flush), .state_dbg(a_state)
  );

  spec_dispatch_staller #(.MAX_BRANCHES(3), .BLOCK_ON_BRANCH(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ifq_empty(ifq_empty[1]), .branch(branch[1]), .jalr(jalr[1]),
    .branch_solved(bsolved[1]), .branch_mispredict(bmisp[1]), .jalr_solved(jsolved[1]),
    .nstall(b_nstall), .dispatch_tag(b_tag), .branch_add_reg_en(b_en), .oldest_tag(b_old),
    .outstanding(b_out), .flush(b_flush), .state_dbg(b_state)
  );

  spec_dispatch_staller #(.MAX_BRANCHES(2), .BLOCK_ON_BRANCH(1'b1)) dut_c (
    .clk(clk), .rst(rst), .ifq_empty(ifq_empty[2]), .branch(branch[2]), .jalr(jalr[2]),
    .branch_solved(bsolved[2]), .branch_mispredict(bmisp[2]), .jalr_solved(jsolved[2]),
    .nstall(c_nstall), .dispatch_tag(c_tag), .branch_add_reg_en(c_en), .oldest_tag(c_old),
    .outstanding(c_out), .flush(c_flush), .state_dbg(c_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic e, input logic br, input logic j,
                     input logic s, input logic m, input logic js);
    ifq_empty[d] = e;
    branch[d]    = br;
    jalr[d]      = j;
    bsolved[d]   = s;
    bmisp[d]     = m;
    jsolved[d]   = js;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drv(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int b_br[8]  = '{1, 1, 1, 1, 1, 0, 1, 1};
  int b_sv[8]  = '{0, 0, 1, 1, 0, 1, 0, 0};
  int b_ot[8]  = '{0, 1, 2, 2, 2, 3, 2, 3};
  int b_ol[8]  = '{0, 0, 0, 1, 2, 2, 0, 0};
  int b_ns[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    do_reset();
    #1;
    check("rst_nstall", a_nstall, 1);
    check("rst_out", a_out, 0);
    check("rst_flush", a_flush, 0);
    check("rst_en", a_en, 0);
    check("rst_tag", a_tag, 0);
    check("rst_old", a_old, 0);
    check("rst_state", a_state, 0);
    check("rst_b_out", b_out, 0);
    check("rst_c_nstall", c_nstall, 1);

    // MAX=2: fill, stall on full, release on solve
    tick();
    drv(0, 0, 1, 0, 0, 0, 0); #1;
    check("a_br0_nstall", a_nstall, 1);
    check("a_br0_en", a_en, 2'b01);
    check("a_br0_tag", a_tag, 0);
    tick();
    drv(0, 0, 1, 0, 0, 0, 0); #1;
    check("a_br1_en", a_en, 2'b10);
    check("a_br1_tag", a_tag, 1);
    check("a_br1_out", a_out, 1);
    tick();
    drv(0, 0, 1, 0, 1, 0, 0); #1;
    check("a_full_nstall", a_nstall, 0);
    check("a_full_en", a_en, 0);
    check("a_full_out", a_out, 2);
    tick();
    drv(0, 0, 1, 0, 0, 0, 0); #1;
    check("a_rel_nstall", a_nstall, 1);
    check("a_rel_en", a_en, 2'b01);
    check("a_rel_tag", a_tag, 0);
    check("a_rel_old", a_old, 1);
    check("a_rel_out", a_out, 1);
    tick();
    drv(0, 0, 0, 0, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0, 0); #1;
    check("a_drain_out", a_out, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    check("a_spurious_out", a_out, 0);
    check("a_spurious_old", a_old, 1);
    // branch on an empty IFQ is ignored
    drv(0, 1, 1, 0, 0, 0, 0); #1;
    check("a_empty_nstall", a_nstall, 0);
    check("a_empty_en", a_en, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    check("a_empty_out", a_out, 0);
    check("a_empty_tag", a_tag, 1);

    // JALR with one branch outstanding
    do_reset();
    drv(0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0); #1;
    check("a_jalr_fire", a_nstall, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 0, 1, 0, 0, (k == 3) ? 1'b1 : 1'b0); #1;
      check("a_jalr_wait_nstall", a_nstall, 0);
      check("a_jalr_wait_state", a_state, 1);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    check("a_jalr_done_state", a_state, 0);
    check("a_jalr_done_nstall", a_nstall, 1);
    check("a_jalr_done_out", a_out, 1);
    drv(0, 0, 1, 1, 0, 0, 0); #1;
    check("a_prio_en", a_en, 2'b10);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    check("a_prio_state", a_state, 0);
    check("a_prio_out", a_out, 2);

    // mispredict while waiting on JALR, with a branch request present
    do_reset();
    drv(0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0, 0); tick();
    drv(0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0); #1;
    check("a_mp_jalr_nstall", a_nstall, 1);
    check("a_mp_pre_old", a_old, 1);
    tick();
    drv(0, 0, 1, 0, 1, 1, 1); #1;
    check("a_mp_nstall", a_nstall, 0);
    check("a_mp_en", a_en, 0);
    tick();
    drv(0, 0, 0, 0, 1, 0, 0); #1;
    check("a_fl_flush", a_flush, 1);
    check("a_fl_state", a_state, 2);
    check("a_fl_nstall", a_nstall, 0);
    check("a_fl_out", a_out, 0);
    check("a_fl_old", a_old, 0);
    check("a_fl_tag", a_tag, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    check("a_post_flush", a_flush, 0);
    check("a_post_state", a_state, 0);
    check("a_post_nstall", a_nstall, 1);
    check("a_post_out", a_out, 0);

    // MAX=3: interleaved dispatch/solve with tail wrap
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, b_br[i][0], 0, b_sv[i][0], 0, 0); #1;
      check("b_out", b_out, b_ot[i]);
      check("b_old", b_old, b_ol[i]);
      check("b_nstall", b_nstall, b_ns[i]);
      if (b_br[i] != 0 && b_ns[i] != 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("b_tag", b_tag, e);
        check("b_en", b_en, 32'd1 << e);
      end else begin
        check("b_en_idle", b_en, 0);
      end
      tick();
    end
    check("b_q_empty", exp_q.size(), 0);

    // blocking mode: any outstanding branch stalls everything
    do_reset();
    drv(2, 0, 1, 0, 0, 0, 0); #1;
    check("c_br_nstall", c_nstall, 1);
    check("c_br_en", c_en, 2'b01);
    tick();
    drv(2, 0, 0, 0, 0, 0, 0); #1;
    check("c_blk_nstall", c_nstall, 0);
    check("c_blk_out", c_out, 1);
    tick();
    drv(2, 0, 0, 0, 1, 0, 0); #1;
    check("c_solve_nstall", c_nstall, 0);
    tick();
    drv(2, 0, 0, 0, 0, 0, 0); #1;
    check("c_rel_nstall", c_nstall, 1);
    check("c_rel_out", c_out, 0);
    check("c_rel_old", c_old, 1);
    drv(2, 0, 1, 0, 0, 0, 0); tick();
    drv(2, 0, 0, 0, 0, 0, 0); #1;
    check("c_blk2_nstall", c_nstall, 0);
    check("c_blk2_out", c_out, 1);
    #1 rst = 1'b1;
    #1;
    check("c_arst_out", c_out, 0);
    check("c_arst_nstall", c_nstall, 1);
    check("c_arst_old", c_old, 0);
    check("c_arst_tag", c_tag, 0);
    #1 rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spec_dispatch_staller.md
# spec_dispatch_staller

Front-end dispatch gate that generalises single-branch stalling to a parametrised number of outstanding speculative branches. Sits between the instruction fetch queue (IFQ) head and the dispatch stage. Allocates a branch tag and branch-address-register slot per dispatched branch, retires tags in order on resolution, stalls on JALR until its target is solved, and issues a one-cycle flush on misprediction.

## Interface
Parameters:
- MAX_BRANCHES, 2, outstanding unresolved branches allowed (≥1, any integer).
- BLOCK_ON_BRANCH, 0, 1 = stall every instruction while any branch is outstanding (legacy single-branch behaviour).
- TAG_W, max(1,$clog2(MAX_BRANCHES)), derived, tag width.
- CNT_W, $clog2(MAX_BRANCHES+1), derived, occupancy width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifq_empty  in  1  IFQ has no instruction at head.
- branch  in  1  head instruction is a conditional branch.
- jalr  in  1  head instruction is JALR.
- branch_solved  in  1  oldest outstanding branch resolved this cycle.
- branch_mispredict  in  1  qualifies branch_solved: resolution was a mispredict.
- jalr_solved  in  1  pending JALR target resolved.
- nstall  out  1  1 = head instruction dispatches this cycle.
- dispatch_tag  out  TAG_W  tag given to a branch dispatched this cycle (= tail pointer).
- branch_add_reg_en  out  MAX_BRANCHES  one-hot write enable of branch-address slot dispatch_tag; all-zero when no branch dispatches.
- oldest_tag  out  TAG_W  tag of oldest outstanding branch (= head pointer).
- outstanding  out  CNT_W  number of unresolved branches.
- flush  out  1  front-end flush request.

## Operation
- States: NORMAL, JALR_WAIT, FLUSH. Registers: state, head, tail, count.
- nstall = !ifq_empty && state==NORMAL && !(branch && count==MAX_BRANCHES) && !(BLOCK_ON_BRANCH && count!=0). Uses registered count only; no same-cycle bypass of a resolution.
- br_fire = nstall && branch; jalr_fire = nstall && jalr.
- br_fire: branch_add_reg_en[tail]=1; tail advances, wrapping MAX_BRANCHES-1 → 0; count+1.
- Valid solve (branch_solved && count!=0): head advances with wrap; count−1. branch_solved with count==0 ignored, no state change.
- Simultaneous br_fire and valid solve: head and tail both advance, count unchanged.
- Transitions: NORMAL→JALR_WAIT on jalr_fire. JALR_WAIT→NORMAL on jalr_solved. jalr_solved outside JALR_WAIT ignored.
- Mispredict (valid solve && branch_mispredict), any state: next state FLUSH, head=tail=0, count=0; overrides concurrent br_fire/jalr_fire allocation and jalr_solved (wrong-path JALR discarded).
- FLUSH: flush=1, nstall=0; unconditionally → NORMAL next cycle. branch_solved in FLUSH ignored.
- branch and jalr both high: branch takes priority; jalr ignored.
- branch/jalr ignored when ifq_empty=1.

## Timing
- Reset values: state=NORMAL, head=tail=count=0; outputs nstall=!ifq_empty (comb), dispatch_tag=0, oldest_tag=0, outstanding=0, flush=0, branch_add_reg_en=0.
- Reset mid-operation clears all outstanding tags and any JALR/FLUSH state immediately (asynchronous).
- nstall, branch_add_reg_en, dispatch_tag combinational from registered state plus inputs; outstanding/oldest_tag/flush purely registered.
- Full stall release latency: solve in cycle N → count drops at edge N+1 → queued branch dispatches in cycle N+1.
- JALR: dispatches in cycle N, nstall=0 from N+1 until cycle after jalr_solved.
- Mispredict in cycle N: flush=1 in cycle N+1 only; dispatch resumes N+2.

## Test plan
- Reset, ifq_empty=0, no branch → nstall=1, outstanding=0, flush=0, branch_add_reg_en=00.
- MAX_BRANCHES=2: three consecutive branches → en=01 tag0, en=10 tag1, third stalls (nstall=0, outstanding=2); branch_solved → third dispatches next cycle with tag0, oldest_tag=1.
- MAX_BRANCHES=3: five branches interleaved with solves; check tail wraps 2→0, same-cycle dispatch+solve holds outstanding constant.
- JALR dispatched with outstanding=1: nstall=0 for 4 cycles until jalr_solved, NORMAL and nstall=1 the cycle after.
- Mispredict in JALR_WAIT with outstanding=2 and a concurrent branch request: flush=1 one cycle, outstanding=0, head=tail=0, no allocation occurs.
- BLOCK_ON_BRANCH=1: one branch → all subsequent non-branch heads stall until branch_solved; rst asserted mid-stall → outstanding=0, nstall=1 immediately.
